// File: rtl/mem_write_ctrl.sv
// rtl/mem_write_ctrl.sv - debounced single-strobe write controller for the 4 x 8-bit memory bank
module mem_write_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DATA_W          = 8,
    parameter int SEL_W           = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_raw,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [SEL_W-1:0]  sw_sel,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [SEL_W-1:0]  wr_sel,
    output logic              busy,
    output logic [7:0]        wr_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS_Q = 3'd1,
        STROBE  = 3'd2,
        HELD    = 3'd3,
        REL_Q   = 3'd4
    } state_t;

    logic              btn_meta_q;
    logic              btn_s_q;
    logic [DATA_W-1:0] data_meta_q;
    logic [DATA_W-1:0] data_s_q;
    logic [SEL_W-1:0]  sel_meta_q;
    logic [SEL_W-1:0]  sel_s_q;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [SEL_W-1:0]  wr_sel_q;
    logic [7:0]        wr_count_q;

    // Two-flop synchronisers bring the button and switches into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            data_meta_q <= '0;
            data_s_q    <= '0;
            sel_meta_q  <= '0;
            sel_s_q     <= '0;
        end else begin
            btn_meta_q  <= btn_raw;
            btn_s_q     <= btn_meta_q;
            data_meta_q <= sw_data;
            data_s_q    <= data_meta_q;
            sel_meta_q  <= sw_sel;
            sel_s_q     <= sel_meta_q;
        end
    end

    // Debounce FSM: qualify press, emit one strobe with captured switches, qualify release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_sel_q   <= '0;
            wr_count_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (btn_s_q) begin
                        state_q <= PRESS_Q;
                    end
                end
                PRESS_Q: begin
                    if (!btn_s_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= STROBE;
                        cnt_q      <= '0;
                        wr_en_q    <= 1'b1;
                        wr_data_q  <= data_s_q;
                        wr_sel_q   <= sel_s_q;
                        wr_count_q <= wr_count_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STROBE: begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                end
                HELD: begin
                    cnt_q <= '0;
                    if (!btn_s_q) begin
                        state_q <= REL_Q;
                    end
                end
                REL_Q: begin
                    if (btn_s_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign wr_sel   = wr_sel_q;
    assign wr_count = wr_count_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_write_ctrl.sv
// tb/tb_mem_write_ctrl.sv - self-checking bench for mem_write_ctrl against a run-length debounce model
module tb_mem_write_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_raw = 1'b0;
    logic [7:0] sw_data = 8'h00;
    logic [1:0] sw_sel = 2'd0;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [1:0] wr_sel;
    logic       busy;
    logic [7:0] wr_count;

    int total = 0;
    int bad = 0;

    mem_write_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .DATA_W(8),
        .SEL_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .sw_data(sw_data),
        .sw_sel(sw_sel),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_sel(wr_sel),
        .busy(busy),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the debounced level flips once the synced button has
    // disagreed with it for D+1 consecutive samples; a rising flip fires a
    // strobe, and the sample right after a strobe is ignored.
    int         cyc = 0;
    logic       m_b0 = 0, m_b1 = 0;
    logic [7:0] m_d0 = 0, m_d1 = 0;
    logic [1:0] m_s0 = 0, m_s1 = 0;
    logic       s_now;
    logic [7:0] d_now;
    logic [1:0] sl_now;
    int         run = 0;
    bit         level = 0, dead = 0;
    logic       e_wr_en = 0, e_busy = 0;
    logic [7:0] e_wr_data = 0, e_wr_count = 0;
    logic [1:0] e_wr_sel = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b0 = 0; m_b1 = 0; m_d0 = 0; m_d1 = 0; m_s0 = 0; m_s1 = 0;
            run = 0; level = 0; dead = 0;
            e_wr_en = 0; e_busy = 0; e_wr_data = 0; e_wr_sel = 0; e_wr_count = 0;
        end else begin
            s_now = m_b1; d_now = m_d1; sl_now = m_s1;
            m_b1 = m_b0; m_b0 = btn_raw;
            m_d1 = m_d0; m_d0 = sw_data;
            m_s1 = m_s0; m_s0 = sw_sel;
            e_wr_en = 0;
            if (dead) begin
                dead = 0;
            end else if (s_now != level) begin
                run++;
                if (run == D + 1) begin
                    level = s_now;
                    run = 0;
                    if (s_now) begin
                        e_wr_en = 1;
                        e_wr_data = d_now;
                        e_wr_sel = sl_now;
                        e_wr_count = e_wr_count + 8'd1;
                        dead = 1;
                    end
                end
            end else begin
                run = 0;
            end
            e_busy = level || (run != 0) || dead;
        end
    end

    int   n_strobe = 0;
    int   last_strobe_cyc = 0;
    logic prev_wr_en = 0;

    // Per-cycle comparison against the model, just after each active edge
    always @(posedge clk) begin
        #1;
        check("wr_en", wr_en, e_wr_en);
        check("busy", busy, e_busy);
        check("wr_count", wr_count, e_wr_count);
        check("wr_data", wr_data, e_wr_data);
        check("wr_sel", wr_sel, e_wr_sel);
        check("no_back2back", prev_wr_en & wr_en, 0);
        if (wr_en === 1'b1) begin
            n_strobe++;
            last_strobe_cyc = cyc;
        end
        prev_wr_en = wr_en;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] d, input logic [1:0] s, input int hi, input int lo);
        sw_data = d;
        sw_sel  = s;
        btn_raw = 1'b1;
        tick(hi);
        btn_raw = 1'b0;
        tick(lo);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    int base;
    int t0;
    bit seen;

    initial begin
        tick(3);
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_count", wr_count, 0);
        rst_n = 1'b1;
        tick(2);

        // Clean press with latency measurement
        base = n_strobe;
        sw_data = 8'hA5; sw_sel = 2'd2;
        btn_raw = 1'b1;
        t0 = cyc;
        tick(20);
        check("clean_one_strobe", n_strobe - base, 1);
        check("clean_latency", last_strobe_cyc - t0, D + 3);
        check("clean_data", wr_data, 8'hA5);
        check("clean_sel", wr_sel, 2);
        check("clean_count", wr_count, 1);
        check("clean_busy_held", busy, 1);
        btn_raw = 1'b0;
        tick(10);
        check("clean_busy_idle", busy, 0);

        // Glitch
        base = n_strobe;
        press(8'h3C, 2'd1, 2, 10);
        check("glitch_no_strobe", n_strobe - base, 0);
        check("glitch_count", wr_count, 1);
        check("glitch_busy", busy, 0);

        // Bounce on press and release
        base = n_strobe;
        for (int i = 0; i < 6; i++) begin
            btn_raw = ~btn_raw;
            tick(1);
        end
        btn_raw = 1'b1;
        tick(10);
        for (int i = 0; i < 3; i++) begin
            btn_raw = ~btn_raw;
            tick(1);
        end
        btn_raw = 1'b0;
        tick(12);
        check("bounce_one_strobe", n_strobe - base, 1);
        check("bounce_busy", busy, 0);

        // Switch change while held
        sw_data = 8'h11; sw_sel = 2'd3;
        btn_raw = 1'b1;
        tick(12);
        sw_data = 8'h22; sw_sel = 2'd0;
        tick(6);
        check("held_data_kept", wr_data, 8'h11);
        check("held_sel_kept", wr_sel, 3);
        btn_raw = 1'b0;
        tick(10);
        press(8'h22, 2'd0, 12, 10);
        check("next_press_data", wr_data, 8'h22);
        check("next_press_sel", wr_sel, 0);

        // Wrap after 256 presses from reset
        do_reset();
        base = n_strobe;
        for (int i = 0; i < 256; i++) begin
            press(8'($urandom), 2'($urandom), 8 + int'($urandom_range(0, 3)), 8 + int'($urandom_range(0, 3)));
        end
        check("wrap_pulses", n_strobe - base, 256);
        check("wrap_count", wr_count, 0);

        // Reset during press qualification, button kept held
        tick(2);
        base = n_strobe;
        btn_raw = 1'b1;
        tick(5);
        check("midq_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midq_clr_busy", busy, 0);
        check("midq_clr_wr_en", wr_en, 0);
        check("midq_clr_count", wr_count, 0);
        tick(2);
        rst_n = 1'b1;
        t0 = cyc;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (n_strobe > base) seen = 1;
        end
        check("midq_strobe_seen", seen, 1);
        check("midq_full_requal", last_strobe_cyc - t0, D + 3);
        check("midq_count", wr_count, 1);
        btn_raw = 1'b0;
        tick(10);

        // Random button activity and switch churn against the model
        for (int i = 0; i < 300; i++) begin
            btn_raw = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                sw_data = 8'($urandom);
                sw_sel  = 2'($urandom);
            end
            tick(int'($urandom_range(1, 9)));
        end
        btn_raw = 1'b0;
        tick(12);
        check("random_busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
